sr_flag_arbiter: RTL and testbench

SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

---
 rtl/sr_flag_arbiter.sv | 133 +++++++++++++
 tb/tb_sr_flag_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: NFLAG set/reset flags written by two requesters, with a sequenced clear sweep.
// Latency: a handshake updates q on the same edge (visible next cycle); a clear sweep takes NFLAG cycles.
// Backpressure: ready is combinational; same-address collisions are serialized round-robin, and sweeps stall both requesters.
// Optional feature: define SR_ARB_CONFLICT_CNT_EN to add an 8-bit saturating conflict_cnt output.
module sr_flag_arbiter #(
  parameter int NFLAG = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic             a_op,
  input  logic [AW-1:0]    a_addr,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_op,
  input  logic [AW-1:0]    b_addr,
  output logic             b_ready,
  input  logic             clr_all,
  output logic             sweep_done,
  output logic             busy,
`ifdef SR_ARB_CONFLICT_CNT_EN
  output logic [7:0]       conflict_cnt,
`endif
  output logic [NFLAG-1:0] q
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              rr_q, rr_d;
  logic [NFLAG-1:0]  flags_q, flags_d;
  logic              last_idx;
  logic              collide;
  logic              coll_grant;

  assign last_idx   = (idx_q == AW'(NFLAG - 1));
  assign collide    = a_valid && b_valid && (a_addr == b_addr);
  // A collision is only resolved (and rr advanced) when one side actually got ready.
  assign coll_grant = collide && (a_ready || b_ready);
  assign q          = flags_q;

  // State register: reset drops straight to IDLE, aborting any sweep in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: clr_all starts a sweep, which ends after clearing the last index.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_all)  state_d = SWEEP;
      SWEEP:   if (last_idx) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: readies are gated by rst so they fall the moment reset rises, not at an edge.
  always_comb begin
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    busy       = 1'b0;
    sweep_done = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (!clr_all) begin
            a_ready = a_valid;
            b_ready = b_valid;
            if (collide) begin
              a_ready = a_valid && !rr_q;
              b_ready = b_valid &&  rr_q;
            end
          end
        end
        SWEEP: begin
          busy       = 1'b1;
          sweep_done = last_idx;
        end
        default: ;
      endcase
    end
  end

  // Flag next-state: sweep clears one index per cycle, otherwise apply granted commands.
  // Granted commands never target the same flag, so the two writes cannot conflict.
  always_comb begin
    flags_d = flags_q;
    if (state_q == SWEEP) begin
      flags_d[idx_q] = 1'b0;
    end else begin
      if (a_ready) flags_d[a_addr] = a_op;
      if (b_ready) flags_d[b_addr] = b_op;
    end
  end

  // Sweep index and round-robin pointer next-state.
  always_comb begin
    idx_d = '0;
    if (state_q == SWEEP && !last_idx) idx_d = idx_q + 1'b1;
    rr_d = coll_grant ? ~rr_q : rr_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      idx_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      flags_q <= flags_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
    end
  end

`ifdef SR_ARB_CONFLICT_CNT_EN
  logic [7:0] cnt_q;
  assign conflict_cnt = cnt_q;

  // Count resolved collisions whose requesters wanted opposite values, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (coll_grant && (a_op != b_op) && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Testbench for sr_flag_arbiter: directed vector table, hand-written sweep/reset sequences,
// and randomized traffic compared against a behavioural model of the flag arbiter.
module tb_sr_flag_arbiter;
  localparam int NFLAG = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             a_valid = 1'b0, a_op = 1'b0, b_valid = 1'b0, b_op = 1'b0, clr_all = 1'b0;
  logic [AW-1:0]    a_addr = '0, b_addr = '0;
  logic             a_ready, b_ready, sweep_done, busy;
  logic [NFLAG-1:0] q;
`ifdef SR_ARB_CONFLICT_CNT_EN
  logic [7:0]       conflict_cnt;
`endif

  sr_flag_arbiter #(.NFLAG(NFLAG), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_op(a_op), .a_addr(a_addr), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_addr(b_addr), .b_ready(b_ready),
    .clr_all(clr_all), .sweep_done(sweep_done), .busy(busy),
`ifdef SR_ARB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .q(q)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic aop, input logic [AW-1:0] aa,
                       input logic bv, input logic bop, input logic [AW-1:0] ba,
                       input logic clr);
    a_valid = av; a_op = aop; a_addr = aa;
    b_valid = bv; b_op = bop; b_addr = ba;
    clr_all = clr;
  endtask

  typedef struct {
    logic          av, aop;
    logic [AW-1:0] aa;
    logic          bv, bop;
    logic [AW-1:0] ba;
    logic          ear, ebr;
    logic [7:0]    eq;
  } vec_t;

  vec_t tbl[10];

  // Behavioural model state: flag array, round-robin pointer, sweep position (-1 = no sweep).
  logic [7:0] mq;
  logic       rr_m;
  int         sweep_pos;
  int         cnt_m;

  initial begin
    logic e_ar, e_br, e_busy, e_sd, coll;
    logic av, aop, bv, bop, clr;
    logic [AW-1:0] aa, ba;

    // av aop aa    bv  bop  ba    ear  ebr  q-after
    tbl[0] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h08};
    tbl[1] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 8'h42};
    tbl[3] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'h46};
    tbl[4] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 8'h42};
    tbl[5] = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b1, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 8'h20};
    tbl[8] = '{1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 8'hA0};
    tbl[9] = '{1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 8'hA0};

    // Reset asserted mid-clock must take effect immediately, with a requester already valid.
    drive(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 3'd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
`ifdef SR_ARB_CONFLICT_CNT_EN
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table starting from reset (q=0, rr=0).
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].av, tbl[i].aop, tbl[i].aa, tbl[i].bv, tbl[i].bop, tbl[i].ba, 1'b0);
      #1;
      chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ear));
      chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].ebr));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].eq));
      @(negedge clk);
    end
`ifdef SR_ARB_CONFLICT_CNT_EN
    chk("vec_conflict_cnt", 32'(conflict_cnt), 32'd2);
`endif

    // Fill all flags, then run a full sweep with A held valid throughout.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, AW'(k), 1'b1, 1'b1, AW'(k + 4), 1'b0);
      @(negedge clk);
    end
    chk("fill_q", 32'(q), 32'hFF);
    drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    #1;
    chk("clr_a_ready", 32'(a_ready), 32'd0);
    chk("clr_busy_pre", 32'(busy), 32'd0);
    @(negedge clk);
    clr_all = 1'b0;
    for (int k = 0; k < NFLAG; k++) begin
      #1;
      chk($sformatf("sweep%0d_busy", k), 32'(busy), 32'd1);
      chk($sformatf("sweep%0d_a_ready", k), 32'(a_ready), 32'd0);
      chk($sformatf("sweep%0d_done", k), 32'(sweep_done), (k == NFLAG - 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      chk($sformatf("sweep%0d_q", k), 32'(q), 32'((32'hFF << (k + 1)) & 32'hFF));
      @(negedge clk);
    end
    #1;
    chk("post_sweep_busy", 32'(busy), 32'd0);
    chk("post_sweep_done", 32'(sweep_done), 32'd0);
    chk("post_sweep_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    chk("post_sweep_q", 32'(q), 32'h01);
    @(negedge clk);

    // Refill, start a sweep, and hit reset when the sweep index reaches 4.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, AW'(k), 1'b1, 1'b1, AW'(k + 4), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    clr_all = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_sweep_q", 32'(q), 32'hF0);
    chk("mid_sweep_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sweep_done", 32'(sweep_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    chk("after_rst_a_ready", 32'(a_ready), 32'd1);
    chk("after_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("after_rst_q", 32'(q), 32'h10);
    chk("after_rst_sweep_done", 32'(sweep_done), 32'd0);
    @(negedge clk);

`ifdef SR_ARB_CONFLICT_CNT_EN
    // 256 opposite-op collisions must saturate the counter at 255.
    drive(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (256) @(negedge clk);
    chk("cnt_saturate", 32'(conflict_cnt), 32'd255);
`endif

    // Randomized traffic against the behavioural model, from a fresh reset.
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq = 8'h00; rr_m = 1'b0; sweep_pos = -1; cnt_m = 0;
    for (int n = 0; n < 1500; n++) begin
      av  = 1'($urandom_range(0, 3) != 0);
      aop = 1'($urandom_range(0, 1));
      aa  = AW'($urandom_range(0, 3));
      bv  = 1'($urandom_range(0, 3) != 0);
      bop = 1'($urandom_range(0, 1));
      ba  = AW'($urandom_range(0, 3));
      clr = 1'($urandom_range(0, 39) == 0);
      drive(av, aop, aa, bv, bop, ba, clr);

      e_busy = (sweep_pos >= 0);
      e_sd   = (sweep_pos == NFLAG - 1);
      e_ar   = 1'b0;
      e_br   = 1'b0;
      coll   = av && bv && (aa == ba);
      if (sweep_pos < 0 && !clr) begin
        e_ar = av;
        e_br = bv;
        if (coll) begin
          if (rr_m) e_ar = 1'b0;
          else      e_br = 1'b0;
        end
      end
      #1;
      chk("rand_a_ready", 32'(a_ready), 32'(e_ar));
      chk("rand_b_ready", 32'(b_ready), 32'(e_br));
      chk("rand_busy", 32'(busy), 32'(e_busy));
      chk("rand_sweep_done", 32'(sweep_done), 32'(e_sd));
`ifdef SR_ARB_CONFLICT_CNT_EN
      chk("rand_cnt", 32'(conflict_cnt), 32'(cnt_m));
`endif

      if (sweep_pos >= 0) begin
        mq[sweep_pos] = 1'b0;
        sweep_pos = (sweep_pos == NFLAG - 1) ? -1 : sweep_pos + 1;
      end else if (clr) begin
        sweep_pos = 0;
      end else begin
        if (e_ar) mq[aa] = aop;
        if (e_br) mq[ba] = bop;
        if (coll) begin
          rr_m = !rr_m;
          if (aop != bop && cnt_m < 255) cnt_m++;
        end
      end

      @(posedge clk); #1;
      chk("rand_q", 32'(q), 32'(mq));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
